// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, machine word and the arbiter's
// state encoding so the datapath and tests can probe the arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t IGRANT = 2'd1;
  localparam arb_state_t DGRANT = 2'd2;
  localparam arb_state_t DONE   = 2'd3;

  localparam word_t WORD_ZERO = 32'h0000_0000;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-ported system RAM between instruction fetch and data
// access: one grant at a time, strobes held until ACCESS, error or timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate,
  output logic       err
);

  arb_state_t state;
  arb_state_t next_state;
  logic       fair;
  logic [7:0] wcnt;
  ramstate_t  rs;
  logic       d_pend;
  logic       timed_out;
  logic       in_grant;
  logic       i_done;
  logic       d_done;
  logic       abort;

  assign rs        = ramstate_t'(ramstate);
  assign d_pend    = dREN | dWEN;
  assign timed_out = (wcnt == TIMEOUT);
  assign in_grant  = (state == IGRANT) || (state == DGRANT);

  // Next state, RAM strobes and the owner's completion pulse
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = WORD_ZERO;
    ramstore   = WORD_ZERO;
    i_done     = 1'b0;
    d_done     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        // fair bit hands a contested slot to fetch after a data completion
        if (d_pend && !(iREN && fair)) begin
          next_state = DGRANT;
        end else if (iREN) begin
          next_state = IGRANT;
        end else begin
          next_state = IDLE;
        end
      end
      IGRANT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if ((rs == ACCESS) || (rs == ERROR) || timed_out) begin
            i_done     = 1'b1;
            abort      = (rs != ACCESS);
            next_state = DONE;
          end else begin
            next_state = IGRANT;
          end
        end
      end
      DGRANT: begin
        if (!d_pend) begin
          next_state = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if ((rs == ACCESS) || (rs == ERROR) || timed_out) begin
            d_done     = 1'b1;
            abort      = (rs != ACCESS);
            next_state = DONE;
          end else begin
            next_state = DGRANT;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign iwait = ~i_done;
  assign dwait = ~d_done;
  assign iload = i_done ? ramload : WORD_ZERO;
  assign dload = d_done ? ramload : WORD_ZERO;

  // State, grant wait counter, fairness bit and sticky error flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      wcnt  <= 8'd0;
      fair  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      if (in_grant && (next_state == state)) begin
        wcnt <= wcnt + 8'd1;
      end else begin
        wcnt <= 8'd0;
      end
      if (d_done) begin
        fair <= 1'b1;
      end else if (i_done) begin
        fair <= 1'b0;
      end else begin
        fair <= fair;
      end
      if (abort) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a behavioural RAM plus a transaction-level
// schedule model predicting grant order, completion cycles, data and err.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam logic [7:0] TMO   = 8'd4;
  localparam int         STUCK = 1000;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       iREN, dREN, dWEN;
  word_t      iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
  logic       iwait, dwait, ramREN, ramWEN, err;
  logic [1:0] ramstate;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t ram_mem [128];
  word_t exp_mem [128];
  int    ram_cnt;
  int    i_busy, i_err_at, d_busy, d_err_at;
  bit    last_data;
  bit    err_exp;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural RAM: BUSY until its per-port latency, ERROR if injected
  task automatic ram_respond();
    int busy;
    int eat;
    if (ramREN || ramWEN) begin
      busy = ramaddr[8] ? d_busy : i_busy;
      eat  = ramaddr[8] ? d_err_at : i_err_at;
      if (ram_cnt == eat) begin
        ramstate = ERROR;
        ramload  = 32'h0;
      end else if (ram_cnt == busy) begin
        ramstate = ACCESS;
        ramload  = ram_mem[ramaddr[8:2]];
      end else begin
        ramstate = BUSY;
        ramload  = 32'h0;
      end
    end else begin
      ramstate = FREE;
      ramload  = 32'h0;
    end
  endtask

  task automatic ram_commit();
    if (ramWEN && (ramstate == ACCESS)) ram_mem[ramaddr[8:2]] = ramstore;
    ram_cnt = (ramREN || ramWEN) ? ram_cnt + 1 : 0;
  endtask

  task automatic cyc(input bit ir, input bit dr, input bit dw);
    @(posedge CLK);
    #1;
    iREN = ir;
    dREN = dr;
    dWEN = dw;
    #1;
    ram_respond();
    #2;
  endtask

  function automatic int dur(input int b, input int e);
    if (e >= 0) return e;
    else if (b >= int'(TMO)) return int'(TMO);
    else return b;
  endfunction

  task automatic run_round(input bit do_i, input bit do_d, input bit d_wr,
                           input word_t ia, input word_t da, input word_t ds,
                           input int ib, input int ie, input int db, input int de);
    int gi, ci, gd, cd, last;
    bit in_i, in_d;
    gi = -1; ci = -1; gd = -1; cd = -1;
    i_busy = ib; i_err_at = ie; d_busy = db; d_err_at = de;
    iaddr = ia; daddr = da; dstore = ds;
    if (do_i && do_d) begin
      if (last_data) begin
        gi = 1; ci = gi + dur(ib, ie); gd = ci + 3; cd = gd + dur(db, de);
      end else begin
        gd = 1; cd = gd + dur(db, de); gi = cd + 3; ci = gi + dur(ib, ie);
      end
    end else if (do_i) begin
      gi = 1; ci = gi + dur(ib, ie);
    end else if (do_d) begin
      gd = 1; cd = gd + dur(db, de);
    end
    last = (ci > cd) ? ci : cd;
    for (int t = 0; t <= last + 2; t++) begin
      cyc(do_i && t <= ci, do_d && !d_wr && t <= cd, do_d && d_wr && t <= cd);
      in_i = do_i && t >= gi && t <= ci;
      in_d = do_d && t >= gd && t <= cd;
      check("iwait", iwait, !(do_i && t == ci));
      check("dwait", dwait, !(do_d && t == cd));
      check("ramREN", ramREN, in_i || (in_d && !d_wr));
      check("ramWEN", ramWEN, in_d && d_wr);
      if (in_i) check("ramaddr_i", ramaddr, ia);
      if (in_d) check("ramaddr_d", ramaddr, da);
      if (in_d && d_wr) check("ramstore", ramstore, ds);
      if (do_i && t == ci && ie < 0 && ib < int'(TMO))
        check("iload", iload, exp_mem[ia[8:2]]);
      if (do_d && !d_wr && t == cd && de < 0 && db < int'(TMO))
        check("dload", dload, exp_mem[da[8:2]]);
      check("err", err, err_exp);
      if (do_i && t == ci) begin
        last_data = 1'b0;
        if (ie >= 0 || ib >= int'(TMO)) err_exp = 1'b1;
      end
      if (do_d && t == cd) begin
        last_data = 1'b1;
        if (de >= 0 || db >= int'(TMO)) err_exp = 1'b1;
        else if (d_wr) exp_mem[da[8:2]] = ds;
      end
      ram_commit();
    end
  endtask

  initial begin
    int    sel, ib, ie, db, de;
    bit    wr;
    word_t ia, da;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
    ramstate = FREE; ramload = 32'h0; ram_cnt = 0;
    i_busy = 0; i_err_at = -1; d_busy = 0; d_err_at = -1;
    last_data = 1'b0; err_exp = 1'b0;
    for (int k = 0; k < 128; k++) begin
      ram_mem[k] = $urandom;
      exp_mem[k] = ram_mem[k];
    end
    ram_mem[16] = 32'h8C22_0004;
    exp_mem[16] = 32'h8C22_0004;

    #3;
    check("rst_iwait", iwait, 32'd1);
    check("rst_dwait", dwait, 32'd1);
    check("rst_ramREN", ramREN, 32'd0);
    check("rst_ramWEN", ramWEN, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
    check("rst_err", err, 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge CLK);
    nRST = 1'b1;

    // directed cases from the plan
    run_round(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, -1, 0, -1);
    run_round(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 0, -1, 3, -1);
    run_round(1'b1, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 1, -1, 2, -1);
    run_round(1'b1, 1'b1, 1'b1, 32'h48, 32'h104, 32'h0BAD_F00D, 0, -1, 1, -1);
    run_round(1'b1, 1'b1, 1'b0, 32'h4C, 32'h104, 32'h0, 2, -1, 0, -1);
    run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h108, 32'h0, 0, -1, STUCK, -1);
    run_round(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1, -1, 0, -1);

    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom_range(1, 3));
      wr  = 1'($urandom_range(0, 1));
      ib  = int'($urandom_range(0, 3));
      db  = int'($urandom_range(0, 3));
      ie  = -1;
      de  = -1;
      if ($urandom_range(0, 9) == 0) ib = STUCK;
      else if (ib > 0 && $urandom_range(0, 7) == 0) ie = int'($urandom_range(0, ib - 1));
      if ($urandom_range(0, 9) == 0) db = STUCK;
      else if (db > 0 && $urandom_range(0, 7) == 0) de = int'($urandom_range(0, db - 1));
      ia = 32'($urandom_range(0, 63)) << 2;
      da = 32'h100 | (32'($urandom_range(0, 63)) << 2);
      run_round(sel[0], sel[1], wr, ia, da, $urandom, ib, ie, db, de);
    end

    // data read withdrawn while RAM is still busy
    d_busy = 3; d_err_at = -1; i_busy = 0; i_err_at = -1;
    daddr = 32'h10C; iaddr = 32'h48;
    cyc(1'b0, 1'b1, 1'b0);
    check("wd_dwait0", dwait, 32'd1);
    ram_commit();
    cyc(1'b0, 1'b1, 1'b0);
    check("wd_ramREN1", ramREN, 32'd1);
    check("wd_dwait1", dwait, 32'd1);
    ram_commit();
    cyc(1'b0, 1'b0, 1'b0);
    check("wd_ramREN2", ramREN, 32'd0);
    check("wd_dwait2", dwait, 32'd1);
    ram_commit();
    cyc(1'b1, 1'b0, 1'b0);
    check("wd_state", 32'(dut.state), 32'(IDLE));
    check("wd_iwait3", iwait, 32'd1);
    ram_commit();
    cyc(1'b1, 1'b0, 1'b0);
    check("wd_ramREN4", ramREN, 32'd1);
    check("wd_ramaddr4", ramaddr, 32'h48);
    check("wd_iwait4", iwait, 32'd0);
    check("wd_iload4", iload, exp_mem[18]);
    last_data = 1'b0;
    ram_commit();
    cyc(1'b0, 1'b0, 1'b0);
    ram_commit();
    cyc(1'b0, 1'b0, 1'b0);
    ram_commit();

    // reset asserted in the middle of a data write grant
    d_busy = STUCK; d_err_at = -1;
    daddr = 32'h110; dstore = 32'h1234_5678;
    cyc(1'b0, 1'b0, 1'b1);
    ram_commit();
    cyc(1'b0, 1'b0, 1'b1);
    check("rm_ramWEN_pre", ramWEN, 32'd1);
    ram_commit();
    #2;
    nRST = 1'b0;
    #1;
    check("rm_ramWEN", ramWEN, 32'd0);
    check("rm_dwait", dwait, 32'd1);
    check("rm_state", 32'(dut.state), 32'(IDLE));
    check("rm_err", err, 32'd0);
    dWEN = 1'b0;
    ram_cnt = 0;
    last_data = 1'b0;
    err_exp = 1'b0;
    ramstate = FREE;
    @(negedge CLK);
    nRST = 1'b1;
    run_round(1'b1, 1'b0, 1'b0, 32'h4C, 32'h0, 32'h0, 1, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
